// File: rtl/dbus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder_pkg
// Description : Shared constants for the data-bus responder. This package
//               holds the MMIO register offsets, the STATUS bit positions and
//               a store-lane helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_responder_pkg;

    // MMIO register offsets within the 256-byte window (word aligned)
    localparam logic [7:0] c_OFF_TXDATA   = 8'h00;
    localparam logic [7:0] c_OFF_STATUS   = 8'h04;
    localparam logic [7:0] c_OFF_CYCLE_LO = 8'h08;
    localparam logic [7:0] c_OFF_CYCLE_HI = 8'h0C;
    localparam logic [7:0] c_OFF_HALT     = 8'h10;

    // STATUS register layout
    localparam int c_STATUS_FULL_BIT  = 0;
    localparam int c_STATUS_EMPTY_BIT = 1;
    localparam int c_STATUS_OVF_BIT   = 2;
    localparam int c_STATUS_COUNT_LSB = 8;

    // Byte lanes touched by a store. The 4-bit result truncates the shift, so
    // any enables that would spill past byte 3 are dropped.
    function automatic logic [3:0] store_lanes(input logic [3:0] en,
                                               input logic [1:0] ofs);
        return en << ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : Synchronous FIFO with an occupancy count. The head entry
//               drives data_o directly and has no bypass path.
//   clk_i    - clock              rst_ni  - async active-low reset
//   push_i   - enqueue data_i     pop_i   - dequeue head
//   data_o   - head entry         full_o/empty_o/count_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_CW-1:0]  count_q, count_d;
    logic             w_do_push, w_do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a
    // push that coincides with a pop.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_comb begin
        count_d = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + c_PW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_PW'(1);
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder
// Description : Data-bus responder with a word RAM, a 256-byte MMIO window
//               (console TX FIFO, status, 64-bit cycle counter, halt register).
//   clk_i / rst_ni          - clock, async active-low reset
//   dbus_en_i               - unshifted store byte enables (0 = no store)
//   dbus_write_addr_i/_data - store address / LSB-aligned store data
//   dbus_read_addr_i        - load address; dbus_read_data_o is combinational
//   tx_valid_o/tx_ready_i   - console byte handshake, tx_data_o = head byte
//   halt_o / halt_code_o    - sticky halt flag and captured code
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  dbus_en_i,
    input  logic [31:0] dbus_write_addr_i,
    input  logic [31:0] dbus_read_addr_i,
    input  logic [31:0] dbus_write_data_i,
    output logic [31:0] dbus_read_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        halt_o,
    output logic [31:0] halt_code_o
);

    localparam int c_AW = $clog2(RAM_WORDS);
    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     mem_q [RAM_WORDS];
    logic [63:0]     cycle_q, cycle_d;
    logic            ovf_q;
    logic            halt_q;
    logic [31:0]     halt_code_q;

    // ---------------- load path ----------------
    logic            w_rd_mmio;
    logic [7:0]      w_rd_off;
    logic [c_AW-1:0] w_rd_idx;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_status;

    // ---------------- store path ----------------
    logic            w_wr_any, w_wr_mmio, w_wr_ram;
    logic [7:0]      w_wr_off;
    logic [c_AW-1:0] w_wr_idx;
    logic [3:0]      w_lanes;
    logic [31:0]     w_wdata_sh;

    // ---------------- FIFO ----------------
    logic            w_push, w_pop, w_full, w_empty;
    logic [c_CW-1:0] w_count;

    // Register decode ignores addr[1:0], so sub-word loads from a register
    // see the shifted register value just as they do for RAM.
    assign w_rd_mmio = (dbus_read_addr_i[31:8] == MMIO_BASE[31:8]);
    assign w_rd_off  = {dbus_read_addr_i[7:2], 2'b00};
    assign w_rd_idx  = dbus_read_addr_i[c_AW+1:2];

    always_comb begin
        w_status = '0;
        w_status[c_STATUS_COUNT_LSB +: 8] = 8'(w_count);
        w_status[c_STATUS_OVF_BIT]        = ovf_q;
        w_status[c_STATUS_EMPTY_BIT]      = w_empty;
        w_status[c_STATUS_FULL_BIT]       = w_full;
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_mmio) begin
            case (w_rd_off)
                c_OFF_STATUS:   w_rd_word = w_status;
                c_OFF_CYCLE_LO: w_rd_word = cycle_q[31:0];
                c_OFF_CYCLE_HI: w_rd_word = cycle_q[63:32];
                default:        w_rd_word = '0;
            endcase
        end else begin
            w_rd_word = mem_q[w_rd_idx];
        end
    end

    assign dbus_read_data_o = w_rd_word >> {dbus_read_addr_i[1:0], 3'b000};

    assign w_wr_any   = (dbus_en_i != 4'b0000);
    assign w_wr_mmio  = w_wr_any && (dbus_write_addr_i[31:8] == MMIO_BASE[31:8]);
    assign w_wr_ram   = w_wr_any && !w_wr_mmio;
    assign w_wr_off   = {dbus_write_addr_i[7:2], 2'b00};
    assign w_wr_idx   = dbus_write_addr_i[c_AW+1:2];
    assign w_lanes    = store_lanes(dbus_en_i, dbus_write_addr_i[1:0]);
    assign w_wdata_sh = dbus_write_data_i << {dbus_write_addr_i[1:0], 3'b000};

    // The RAM is not reset. A same-cycle load sees the old word because the
    // write lands at the clock edge.
    always_ff @(posedge clk_i) begin
        if (w_wr_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    mem_q[w_wr_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign w_push = w_wr_mmio && (w_wr_off == c_OFF_TXDATA) && dbus_en_i[0];
    assign w_pop  = tx_valid_o && tx_ready_i;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (dbus_write_data_i[7:0]),
        .pop_i   (w_pop),
        .data_o  (tx_data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign tx_valid_o = !w_empty;

    assign cycle_d = cycle_q + 64'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q     <= '0;
            ovf_q       <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            // A push into a full FIFO is lost only if no pop frees a slot.
            if (w_push && w_full && !w_pop) begin
                ovf_q <= 1'b1;
            end
            if (w_wr_mmio && (w_wr_off == c_OFF_HALT) && !halt_q) begin
                halt_q      <= 1'b1;
                halt_code_q <= dbus_write_data_i;
            end
        end
    end

    assign halt_o      = halt_q;
    assign halt_code_o = halt_code_q;

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_responder
// Description : Self-checking bench for dbus_responder. Console bytes are
//               queued as expected values when pushed and compared on pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;

    localparam logic [31:0] c_BASE = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  dbus_en_i = 4'h0;
    logic [31:0] dbus_write_addr_i = '0;
    logic [31:0] dbus_read_addr_i = '0;
    logic [31:0] dbus_write_data_i = '0;
    logic [31:0] dbus_read_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        halt_o;
    logic [31:0] halt_code_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] rd;

    dbus_responder #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (c_BASE)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .dbus_en_i         (dbus_en_i),
        .dbus_write_addr_i (dbus_write_addr_i),
        .dbus_read_addr_i  (dbus_read_addr_i),
        .dbus_write_data_i (dbus_write_data_i),
        .dbus_read_data_o  (dbus_read_data_o),
        .tx_valid_o        (tx_valid_o),
        .tx_ready_i        (tx_ready_i),
        .tx_data_o         (tx_data_o),
        .halt_o            (halt_o),
        .halt_code_o       (halt_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pops are sampled mid-cycle; the pop itself commits at the next edge.
    always @(negedge clk_i) begin
        if (rst_ni && tx_valid_o && tx_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("tx_unexpected_pop", {24'd0, tx_data_o}, 32'h1FF);
            end else begin
                chk("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
        @(posedge clk_i); #1;
        dbus_write_addr_i = a;
        dbus_write_data_i = d;
        dbus_en_i         = e;
        @(posedge clk_i); #1;
        dbus_en_i = 4'h0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        dbus_read_addr_i = a;
        #1;
        d = dbus_read_data_o;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        tx_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        tx_ready_i = 1'b0;
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_halt_code", halt_code_o, 32'd0);
        load(c_BASE + 32'h04, rd); chk("rst_status", rd, 32'h0000_0002);

        // ---------------- cycle counter ----------------
        @(negedge clk_i); rst_ni = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        load(c_BASE + 32'h08, rd); chk("cycle_lo_10", rd, 32'd10);
        load(c_BASE + 32'h0C, rd); chk("cycle_hi", rd, 32'd0);

        // ---------------- RAM loads/stores ----------------
        store(32'h100, 32'h1122_3344, 4'hF);
        load(32'h101, rd); chk("lb_101", rd & 32'hFF, 32'h33);
        chk("lb_101_zero_fill", rd, 32'h0011_2233);
        load(32'h102, rd); chk("lh_102", rd & 32'hFFFF, 32'h1122);
        load(32'h100, rd); chk("lw_100", rd, 32'h1122_3344);
        store(32'h103, 32'h0000_00AA, 4'h1);
        load(32'h100, rd); chk("sb_103", rd, 32'hAA22_3344);
        store(32'h103, 32'h0000_BBCC, 4'h3);
        load(32'h100, rd); chk("sh_103_drop", rd, 32'hCC22_3344);

        // same-word load during store sees the old value
        @(posedge clk_i); #1;
        dbus_read_addr_i  = 32'h100;
        dbus_write_addr_i = 32'h100;
        dbus_write_data_i = 32'h5566_7788;
        dbus_en_i         = 4'hF;
        #1;
        chk("rd_before_store", dbus_read_data_o, 32'hCC22_3344);
        @(posedge clk_i); #1;
        dbus_en_i = 4'h0;
        chk("rd_after_store", dbus_read_data_o, 32'h5566_7788);
        load(32'h100 + 32'd4096, rd); chk("ram_alias", rd, 32'h5566_7788);

        // ---------------- FIFO overflow then drain ----------------
        for (int i = 0; i < 9; i++) begin
            store(c_BASE, 32'h41 + 32'(i), 4'h1);
            if (i < 8) exp_q.push_back(8'(8'h41 + i));
        end
        load(c_BASE + 32'h04, rd); chk("status_full_ovf", rd, 32'h0000_0805);
        chk("tx_valid_full", 32'(tx_valid_o), 32'd1);
        drain(50);
        load(c_BASE + 32'h04, rd); chk("status_empty_ovf", rd, 32'h0000_0006);

        // ---------------- push while full and popping ----------------
        @(negedge clk_i); rst_ni = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            store(c_BASE, 32'h60 + 32'(i), 4'h1);
            exp_q.push_back(8'(8'h60 + i));
        end
        load(c_BASE + 32'h04, rd); chk("status_full", rd, 32'h0000_0801);
        @(posedge clk_i); #1;
        dbus_write_addr_i = c_BASE;
        dbus_write_data_i = 32'h5A;
        dbus_en_i         = 4'h1;
        tx_ready_i        = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk_i); #1;
        dbus_en_i  = 4'h0;
        tx_ready_i = 1'b0;
        load(c_BASE + 32'h04, rd); chk("status_push_pop_full", rd, 32'h0000_0801);
        drain(50);
        load(c_BASE + 32'h04, rd); chk("status_drained", rd, 32'h0000_0002);

        // ---------------- reset with bytes queued ----------------
        for (int i = 0; i < 3; i++) begin
            store(c_BASE, 32'h70 + 32'(i), 4'h1);
            exp_q.push_back(8'(8'h70 + i));
        end
        chk("tx_valid_queued", 32'(tx_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("tx_valid_async_rst", 32'(tx_valid_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        load(c_BASE + 32'h04, rd); chk("status_after_rst", rd, 32'h0000_0002);
        chk("tx_valid_after_rst", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        tx_ready_i = 1'b0;

        // ---------------- halt and unmapped offsets ----------------
        store(c_BASE + 32'h10, 32'h1, 4'hF);
        chk("halt_first", 32'(halt_o), 32'd1);
        chk("halt_code_first", halt_code_o, 32'h1);
        store(c_BASE + 32'h10, 32'h2, 4'hF);
        chk("halt_sticky", 32'(halt_o), 32'd1);
        chk("halt_code_kept", halt_code_o, 32'h1);
        store(c_BASE + 32'h20, 32'hDEAD_BEEF, 4'hF);
        load(c_BASE + 32'h20, rd); chk("unmapped_read", rd, 32'd0);
        load(c_BASE + 32'h00, rd); chk("txdata_read", rd, 32'd0);
        load(c_BASE + 32'h04, rd); chk("status_no_side_push", rd, 32'h0000_0002);
        store(32'h200, 32'hCAFE_F00D, 4'hF);
        load(32'h200, rd); chk("ram_after_halt", rd, 32'hCAFE_F00D);
        load(32'h100, rd); chk("ram_kept_over_rst", rd, 32'h5566_7788);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024: data RAM depth in 32-bit words, power of two.
REQ-002 Parameter FIFO_DEPTH, default 8: console TX FIFO depth in bytes, power of two, at least 2.
REQ-003 Parameter MMIO_BASE, default 32'h8000_0000: base address of the MMIO window; bits [7:0] zero.
REQ-004 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 Port dbus_en_i, input, 4: store byte enables, unshifted (1=byte, 3=half, 15=word, 0=no store).
REQ-007 Port dbus_write_addr_i, input, 32: store byte address.
REQ-008 Port dbus_read_addr_i, input, 32: load byte address, always driven.
REQ-009 Port dbus_write_data_i, input, 32: store data, LSB-aligned.
REQ-010 Port dbus_read_data_o, output, 32: load data, LSB-aligned.
REQ-011 Port tx_valid_o, input/output pair with tx_ready_i (input, 1): console byte handshake; tx_valid_o is an output, 1 bit.
REQ-012 Port tx_data_o, output, 8: console byte at FIFO head.
REQ-013 Port halt_o, output, 1: sticky halt flag.
REQ-014 Port halt_code_o, output, 32: value written to HALT register.

Function
REQ-015 Address decode: MMIO when addr[31:8]==MMIO_BASE[31:8], else RAM with word index addr[log2(RAM_WORDS)+1:2] (upper bits ignored, aliasing).
REQ-016 Loads are combinational: dbus_read_data_o = selected word >> (8*dbus_read_addr_i[1:0]), zero-filled; zero latency.
REQ-017 RAM store at rising edge when dbus_en_i!=0: lanes = (dbus_en_i << addr[1:0]) truncated to 4 bits, data = dbus_write_data_i << (8*addr[1:0]); lanes past byte 3 dropped.
REQ-018 Load and store to the same RAM word in one cycle: read returns the pre-store value.
REQ-019 MMIO offsets: 0x00 TXDATA (W), 0x04 STATUS (R), 0x08 CYCLE_LO (R), 0x0C CYCLE_HI (R), 0x10 HALT (W); other offsets read 0, writes ignored.
REQ-020 STATUS = {count zero-extended in [15:8], 5'b0, overflow[2], empty[1], full[0]}.
REQ-021 Write to TXDATA with dbus_en_i[0]=1 pushes dbus_write_data_i[7:0]; pushes into a full FIFO with no same-cycle pop are dropped and set sticky overflow.
REQ-022 Pop occurs when tx_valid_o && tx_ready_i; tx_valid_o = !empty; tx_data_o = head byte, stable while tx_valid_o && !tx_ready_i.
REQ-023 Simultaneous push and pop: both take effect, count unchanged, including when full; when empty, pushed byte appears at tx_valid_o the next cycle (no bypass).
REQ-024 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-025 64-bit cycle counter increments every cycle, wraps to 0 after all-ones; CYCLE_LO/HI read its current value.
REQ-026 First write to HALT sets halt_o=1 and captures halt_code_o from dbus_write_data_i; later HALT writes ignored; RAM and FIFO keep operating.

Reset
REQ-027 On rst_ni low, asynchronously: FIFO pointers/count 0, overflow 0, tx_valid_o 0, cycle counter 0, halt_o 0, halt_code_o 0.
REQ-028 RAM contents are not affected by reset.
REQ-029 Reset asserted mid-transfer discards FIFO contents; no partial byte is presented after release.

Structure
REQ-030 Shared package holds MMIO offset constants and STATUS bit positions.
REQ-031 FIFO is one sub-module, tx_fifo, parameterized by depth and width.

Verification
REQ-032 SW 0x11223344 to 0x100, then LB/LH/LW reading 0x101, 0x102, 0x100 -> 0x33, 0x1122, 0x11223344.
REQ-033 SB 0xAA to 0x103 over 0x11223344 -> word 0xAA223344; SH at 0x103 -> only byte 3 written.
REQ-034 tx_ready_i=0, push 9 bytes 0x41..0x49 -> STATUS full=1, overflow=1, count=8; raise tx_ready_i -> 0x41..0x48 in order, then empty=1.
REQ-035 FIFO full, push 0x5A while popping -> pop accepted, 0x5A enqueued, overflow stays 0.
REQ-036 Reset released, read CYCLE_LO after 10 edges -> 10; write HALT 0x1 then 0x2 -> halt_o=1, halt_code_o=0x1.
REQ-037 Reset asserted with 3 bytes queued -> tx_valid_o falls immediately, STATUS empty=1 after release.
